// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// operation codes, FSM states and the default datapath width.
package muldiv_seq_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// Single shared add/subtract step: res = x + y or x - y.
// co is the carry out when adding and the borrow out when subtracting.
module muldiv_step #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] res,
    output logic         co
);

    logic [N-1:0] y_s;
    logic [N:0]   sum_s;

    // Two's-complement add; subtraction inverts y and injects a carry-in
    always_comb begin
        if (sub) begin
            y_s = ~y;
        end else begin
            y_s = y;
        end
        sum_s = {1'b0, x} + {1'b0, y_s} + {{N{1'b0}}, sub};
        res   = sum_s[N-1:0];
        if (sub) begin
            co = ~sum_s[N];
        end else begin
            co = sum_s[N];
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shift-add or
// restoring-divide step per cycle, plus direct MTHI/MTLO writes when idle.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_signed_s, is_div_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     step_x_s, step_res_s;
    logic               step_sub_s, step_co_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_hi_s, fix_lo_s;

    // Operation decode and operand magnitudes for the signed variants
    always_comb begin
        is_signed_s = (op_q == OP_MULT) || (op_q == OP_DIV);
        is_div_s    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        if (is_signed_s && a_q[WIDTH-1]) begin
            mag_a_s = {WIDTH{1'b0}} - a_q;
        end else begin
            mag_a_s = a_q;
        end
        if (is_signed_s && b_q[WIDTH-1]) begin
            mag_b_s = {WIDTH{1'b0}} - b_q;
        end else begin
            mag_b_s = b_q;
        end
    end

    // Divide trials the shifted remainder (including the bit shifted out of the top)
    always_comb begin
        if (is_div_s) begin
            step_x_s   = acc_q[2*WIDTH-1:WIDTH-1];
            step_sub_s = 1'b1;
        end else begin
            step_x_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            step_sub_s = 1'b0;
        end
    end

    muldiv_step #(.N(WIDTH + 1)) u_step (
        .x   (step_x_s),
        .y   ({1'b0, opnd_q}),
        .sub (step_sub_s),
        .res (step_res_s),
        .co  (step_co_s)
    );

    // Sign correction applied to the raw magnitudes in the FIX cycle
    always_comb begin
        if (!is_div_s && res_neg_q) begin
            prod_s = {(2*WIDTH){1'b0}} - acc_q;
        end else begin
            prod_s = acc_q;
        end
        if (is_div_s && res_neg_q) begin
            quo_s = {WIDTH{1'b0}} - acc_q[WIDTH-1:0];
        end else begin
            quo_s = acc_q[WIDTH-1:0];
        end
        if (is_div_s && rem_neg_q) begin
            rem_s = {WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH];
        end else begin
            rem_s = acc_q[2*WIDTH-1:WIDTH];
        end
        if (is_div_s) begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = ST_PREP;
                end else if (!start) begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    // Low half starts as the multiplier (shifted out) or the dividend (shifted up)
                    if (is_div_s) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a_s};
                        opnd_d = mag_b_s;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b_s};
                        opnd_d = mag_a_s;
                    end
                    res_neg_d = is_signed_s & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rem_neg_d = is_signed_s & a_q[WIDTH-1];
                    cnt_d     = {CW{1'b0}};
                    state_d   = ST_ITER;
                end
            end
            ST_ITER: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_s) begin
                        if (!step_co_s) begin
                            acc_d = {step_res_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (acc_q[0]) begin
                            acc_d = {step_res_s, acc_q[WIDTH-1:1]};
                        end else begin
                            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                        end
                    end
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = fix_hi_s;
                    lo_d    = fix_lo_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_PREP) || (state_d == ST_ITER);
    end

    // State and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            op_q      <= OP_MULT;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus random model-checked
// operations through a scoreboard, then cancel, reset and MTHI/MTLO sequences.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, cancel, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    muldiv_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference results from native 64-bit arithmetic (no zero divisors here)
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        int          sx, sy;
        longint      p;
        logic [63:0] u;
        sx = x;
        sy = y;
        r.hi = 32'd0;
        r.lo = 32'd0;
        case (o)
            2'd0: begin
                p    = longint'(sx) * longint'(sy);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'd1: begin
                u    = {32'd0, x} * {32'd0, y};
                r.hi = u[63:32];
                r.lo = u[31:0];
            end
            2'd2: begin
                r.lo = sx / sy;
                r.hi = sx % sy;
            end
            default: begin
                r.lo = x / y;
                r.hi = x % y;
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   lat;
        int   bc;
        e.hi = ehi;
        e.lo = elo;
        sb_q.push_back(e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bc    = 0;
        while (!done && lat < 60) begin
            if (busy) bc++;
            tick();
            lat++;
        end
        check32({name, " latency"}, lat, 32'd34);
        check32({name, " busy_cycles"}, bc, 32'd33);
        if (done) begin
            e = sb_q.pop_front();
            check32({name, " hi"}, hi, e.hi);
            check32({name, " lo"}, lo, e.lo);
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    initial begin
        exp_t         m;
        logic [1:0]   ro;
        logic [31:0]  ra, rb;
        int           seen;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001};
        vecs[9] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        op     = 2'd0;
        a      = 32'd0;
        b      = 32'd0;
        wdata  = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check32("reset busy", {31'd0, busy}, 32'd0);
        check32("reset done", {31'd0, done}, 32'd0);
        check32("reset hi", hi, 32'd0);
        check32("reset lo", lo, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(3, 0));
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0 || rb == 32'hFFFFFFFF) rb = 32'h00000003;
            m = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, m.hi, m.lo);
        end

        // MTHI/MTLO preload, then cancel a DIVU at iteration 10
        hi_we = 1'b1;
        wdata = 32'hAAAA0000;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h00005555;
        tick();
        lo_we = 1'b0;
        check32("mthi", hi, 32'hAAAA0000);
        check32("mtlo", lo, 32'h00005555);
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check32("cancel busy", {31'd0, busy}, 32'd0);
        check32("cancel hi", hi, 32'hAAAA0000);
        check32("cancel lo", lo, 32'h00005555);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        check32("cancel no_done", seen, 32'd0);
        run_op("after_cancel", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        // start together with cancel in IDLE is suppressed
        op     = OP_MULTU;
        start  = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check32("start_cancel busy", {31'd0, busy}, 32'd0);

        // hi_we and start while busy are ignored, then reset mid-ITER
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h00001234;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = OP_MULT;
        a     = 32'd5;
        b     = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        hi_we = 1'b1;
        wdata = 32'hFFFFFFFF;
        op    = OP_DIVU;
        start = 1'b1;
        tick();
        hi_we = 1'b0;
        start = 1'b0;
        check32("busy_write hi", hi, 32'h00001234);
        check32("busy_write busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        #2;
        check32("async_reset busy", {31'd0, busy}, 32'd0);
        check32("async_reset done", {31'd0, done}, 32'd0);
        check32("async_reset hi", hi, 32'd0);
        check32("async_reset lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        run_op("after_reset", OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25);

        check32("scoreboard empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
